fifo_wr_ctrl: RTL and testbench
===============================

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, write data width in bits.
REQ-002 Parameter DEPTH, default 16, FIFO entries; power of two, >=2.
REQ-003 Parameter AFULL_TH, default DEPTH-2, occupancy at or above which almost-full asserts; range 1..DEPTH.
REQ-004 Parameter ERR_STICKY, default 1; 1 = error flag held until cleared, 0 = one-cycle pulse.
REQ-005 Derived AW = log2(DEPTH); CW = AW+1.
REQ-006 CLK  in  1  clock, all state on rising edge.
REQ-007 nRST  in  1  reset, asynchronous, active-low.
REQ-008 wr_en  in  1  push request.
REQ-009 wr_data  in  DATA_W  push data.
REQ-010 rd_pop  in  1  read side consumed one entry this cycle (same clock domain).
REQ-011 err_clr  in  1  clears sticky write error.
REQ-012 mem_wr_en  out  1  registered memory write strobe.
REQ-013 mem_waddr  out  AW  registered memory write address.
REQ-014 mem_wdata  out  DATA_W  registered memory write data.
REQ-015 fifo_full  out  1  registered full flag.
REQ-016 fifo_afull  out  1  registered almost-full flag.
REQ-017 fifo_wr_err  out  1  registered overflow error flag.
REQ-018 fifo_count  out  CW  registered occupancy, 0..DEPTH.

Function
REQ-019 Push accepted in a cycle iff wr_en=1 and fifo_full=1 is false (current registered value); pop in the same cycle does not unblock a push when full.
REQ-020 Accepted push: next cycle mem_wr_en=1, mem_waddr=write pointer before increment, mem_wdata=wr_data sampled; otherwise mem_wr_en=0, mem_waddr/mem_wdata hold last values.
REQ-021 Write pointer (AW bits) increments by 1 per accepted push, wraps DEPTH-1 -> 0.
REQ-022 Pop effective iff rd_pop=1 and fifo_count>0; rd_pop at count 0 ignored, no error.
REQ-023 Count next = count + push_acc - pop_eff; simultaneous accepted push and effective pop leave count unchanged.
REQ-024 fifo_full next = (count next == DEPTH); fifo_afull next = (count next >= AFULL_TH); both reflect count in the same cycle fifo_count updates (1-cycle latency from inputs).
REQ-025 Overflow event = wr_en=1 while fifo_full=1; write dropped, pointer and count unaffected by it.
REQ-026 ERR_STICKY=1: fifo_wr_err sets cycle after overflow event, holds until err_clr=1 clears it next cycle; overflow and err_clr same cycle -> flag set (error wins).
REQ-027 ERR_STICKY=0: fifo_wr_err=1 exactly the cycle after each overflow event, else 0; err_clr ignored.
REQ-028 No arithmetic overflow: count never exceeds DEPTH nor goes below 0.

Reset
REQ-029 nRST=0 asynchronously forces: mem_wr_en=0, mem_waddr=0, mem_wdata=0, write pointer=0, fifo_count=0, fifo_full=0, fifo_afull=0 (AFULL_TH>=1), fifo_wr_err=0.
REQ-030 Reset mid-operation discards all in-flight pushes; first accepted push after release writes address 0.
REQ-031 Outputs first change on the first rising CLK after nRST deasserts.

Verification (DEPTH=4, AFULL_TH=3, DATA_W=8)
REQ-032 Reset, then 4 pushes 0xA0..0xA3 -> mem_wr_en pulses at addresses 0,1,2,3 with matching data; fifo_afull=1 after 3rd, fifo_full=1 after 4th, fifo_count=4.
REQ-033 Full, wr_en=1 with 0xFF -> no mem_wr_en, count stays 4, fifo_wr_err=1 next cycle and held (ERR_STICKY=1) until err_clr pulse; err_clr together with another overflow -> flag stays 1.
REQ-034 Count 2, wr_en and rd_pop same cycle -> count stays 2, mem write issued at current pointer; full, wr_en+rd_pop -> push dropped, count 3, error flagged.
REQ-035 Drain to 0 then rd_pop for 3 cycles -> count stays 0, no error; 5 further pushes -> addresses 0,1,2,3 then wrap verified after pop at address 0.
REQ-036 Assert nRST between two pushes mid-burst -> all outputs 0 immediately without clock; next push writes address 0, count 1.
REQ-037 ERR_STICKY=0 build, two consecutive overflow cycles -> fifo_wr_err high for exactly two cycles, then 0.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for a single-clock FIFO: tracks the write pointer and occupancy,
// registers the memory write strobe, address and data, and raises full, almost-full and overflow flags.
module fifo_wr_ctrl #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter bit ERR_STICKY = 1'b1,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_pop,
  input  logic              i_err_clr,
  output logic              o_mem_wr_en,
  output logic [AW-1:0]     o_mem_waddr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_fifo_full,
  output logic              o_fifo_afull,
  output logic              o_fifo_wr_err,
  output logic [CW-1:0]     o_fifo_count
);

  logic              r_mem_wr_en;
  logic [AW-1:0]     r_mem_waddr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [AW-1:0]     r_wptr;
  logic [CW-1:0]     r_count;
  logic              r_full;
  logic              r_afull;
  logic              r_err;

  logic              w_push_acc;
  logic              w_pop_eff;
  logic              w_ovf;
  logic [CW-1:0]     w_count_nxt;

  // Acceptance uses the registered full flag, so a same-cycle pop never frees room for a push.
  assign w_push_acc = i_wr_en & ~r_full;
  assign w_ovf      = i_wr_en &  r_full;
  assign w_pop_eff  = i_rd_pop & (r_count != '0);

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_count_nxt = r_count;
    if (w_push_acc && !w_pop_eff)
      w_count_nxt = r_count + CW'(1);
    else if (!w_push_acc && w_pop_eff)
      w_count_nxt = r_count - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_mem_wr_en <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      r_wptr      <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_afull     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_wr_en <= w_push_acc;
      if (w_push_acc) begin
        r_mem_waddr <= r_wptr;
        r_mem_wdata <= i_wr_data;
        r_wptr      <= r_wptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_afull <= (w_count_nxt >= CW'(AFULL_TH));
      if (ERR_STICKY) begin
        // A new overflow takes priority over a clear in the same cycle.
        if (w_ovf)
          r_err <= 1'b1;
        else if (i_err_clr)
          r_err <= 1'b0;
      end else begin
        r_err <= w_ovf;
      end
    end
  end

  assign o_mem_wr_en   = r_mem_wr_en;
  assign o_mem_waddr   = r_mem_waddr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_fifo_full   = r_full;
  assign o_fifo_afull  = r_afull;
  assign o_fifo_wr_err = r_err;
  assign o_fifo_count  = r_count;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl with DEPTH=4, AFULL_TH=3, DATA_W=8; a sticky-error and a
// pulse-error instance share the same stimulus.
module tb_fifo_wr_ctrl;

  logic       CLK;
  logic       nRST;
  logic       i_wr_en;
  logic [7:0] i_wr_data;
  logic       i_rd_pop;
  logic       i_err_clr;

  logic       s_mem_wr_en, s_full, s_afull, s_err;
  logic [1:0] s_waddr;
  logic [7:0] s_wdata;
  logic [2:0] s_count;

  logic       p_mem_wr_en, p_full, p_afull, p_err;
  logic [1:0] p_waddr;
  logic [7:0] p_wdata;
  logic [2:0] p_count;

  int total = 0;
  int bad   = 0;

  fifo_wr_ctrl #(.DATA_W(8), .DEPTH(4), .AFULL_TH(3), .ERR_STICKY(1'b1)) u_sticky (
    .CLK(CLK), .nRST(nRST), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
    .i_rd_pop(i_rd_pop), .i_err_clr(i_err_clr),
    .o_mem_wr_en(s_mem_wr_en), .o_mem_waddr(s_waddr), .o_mem_wdata(s_wdata),
    .o_fifo_full(s_full), .o_fifo_afull(s_afull), .o_fifo_wr_err(s_err),
    .o_fifo_count(s_count)
  );

  fifo_wr_ctrl #(.DATA_W(8), .DEPTH(4), .AFULL_TH(3), .ERR_STICKY(1'b0)) u_pulse (
    .CLK(CLK), .nRST(nRST), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
    .i_rd_pop(i_rd_pop), .i_err_clr(i_err_clr),
    .o_mem_wr_en(p_mem_wr_en), .o_mem_waddr(p_waddr), .o_mem_wdata(p_wdata),
    .o_fifo_full(p_full), .o_fifo_afull(p_afull), .o_fifo_wr_err(p_err),
    .o_fifo_count(p_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one clock and settle just past the edge before sampling.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic wr, input logic [7:0] d, input logic pop, input logic clr);
    i_wr_en   = wr;
    i_wr_data = d;
    i_rd_pop  = pop;
    i_err_clr = clr;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".wr_en"}, 32'(s_mem_wr_en), 0);
    check({tag, ".waddr"}, 32'(s_waddr), 0);
    check({tag, ".wdata"}, 32'(s_wdata), 0);
    check({tag, ".count"}, 32'(s_count), 0);
    check({tag, ".full"},  32'(s_full), 0);
    check({tag, ".afull"}, 32'(s_afull), 0);
    check({tag, ".err"},   32'(s_err), 0);
    check({tag, ".p_err"}, 32'(p_err), 0);
  endtask

  logic [1:0] exp_ptr;

  initial begin
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    nRST = 1'b0;
    #23;
    check_all_zero("rst");
    step();
    nRST = 1'b1;

    // Fill: addresses 0..3, afull after the third push, full after the fourth.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      step();
      check("fill.wr_en", 32'(s_mem_wr_en), 1);
      check("fill.waddr", 32'(s_waddr), 32'(i));
      check("fill.wdata", 32'(s_wdata), 32'hA0 + 32'(i));
      check("fill.count", 32'(s_count), 32'(i + 1));
      check("fill.afull", 32'(s_afull), (i >= 2) ? 1 : 0);
      check("fill.full",  32'(s_full),  (i == 3) ? 1 : 0);
    end

    // Overflow while full: write dropped, error set and held.
    set_in(1'b1, 8'hFF, 1'b0, 1'b0);
    step();
    check("ovf.wr_en", 32'(s_mem_wr_en), 0);
    check("ovf.count", 32'(s_count), 4);
    check("ovf.waddr", 32'(s_waddr), 3);
    check("ovf.wdata", 32'(s_wdata), 32'hA3);
    check("ovf.err",   32'(s_err), 1);
    check("ovf.p_err", 32'(p_err), 1);
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check("hold1.err",   32'(s_err), 1);
    check("hold1.p_err", 32'(p_err), 0);
    step();
    check("hold2.err", 32'(s_err), 1);
    set_in(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    check("clr.err", 32'(s_err), 0);

    // Clear together with a fresh overflow: error wins.
    set_in(1'b1, 8'hFF, 1'b0, 1'b1);
    step();
    check("clr_ovf.err", 32'(s_err), 1);
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check("clr_ovf.hold", 32'(s_err), 1);

    // Two back-to-back overflows: pulse build is high exactly two cycles.
    set_in(1'b1, 8'hFF, 1'b0, 1'b0);
    step();
    check("p2.first", 32'(p_err), 1);
    step();
    check("p2.second", 32'(p_err), 1);
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check("p2.after", 32'(p_err), 0);
    check("p2.sticky", 32'(s_err), 1);
    set_in(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    check("clr2.err", 32'(s_err), 0);

    // Full with push+pop: push dropped, pop taken, error flagged.
    set_in(1'b1, 8'hBB, 1'b1, 1'b0);
    step();
    check("fpp.wr_en", 32'(s_mem_wr_en), 0);
    check("fpp.count", 32'(s_count), 3);
    check("fpp.full",  32'(s_full), 0);
    check("fpp.afull", 32'(s_afull), 1);
    check("fpp.err",   32'(s_err), 1);
    set_in(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    check("clr3.err", 32'(s_err), 0);

    // Pop to 2, then push+pop together: count holds, write at pointer 0 (wrapped).
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    check("pop.count", 32'(s_count), 2);
    check("pop.afull", 32'(s_afull), 0);
    set_in(1'b1, 8'hC0, 1'b1, 1'b0);
    step();
    check("pp.wr_en", 32'(s_mem_wr_en), 1);
    check("pp.waddr", 32'(s_waddr), 0);
    check("pp.wdata", 32'(s_wdata), 32'hC0);
    check("pp.count", 32'(s_count), 2);

    // Drain, then pop on empty for three cycles: nothing moves, no error.
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    step();
    check("drain.count", 32'(s_count), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("empty_pop.count", 32'(s_count), 0);
      check("empty_pop.err",   32'(s_err), 0);
    end

    // Four pushes wrap the pointer 1,2,3,0; a pop then lets a fifth push in at address 1.
    exp_ptr = 2'd1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
      step();
      check("wrap.waddr", 32'(s_waddr), 32'(exp_ptr));
      check("wrap.wdata", 32'(s_wdata), 32'hE0 + 32'(i));
      exp_ptr = exp_ptr + 2'd1;
    end
    check("wrap.full", 32'(s_full), 1);
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    check("wrap.pop", 32'(s_count), 3);
    set_in(1'b1, 8'hE4, 1'b0, 1'b0);
    step();
    check("wrap5.wr_en", 32'(s_mem_wr_en), 1);
    check("wrap5.waddr", 32'(s_waddr), 32'(exp_ptr));
    check("wrap5.count", 32'(s_count), 4);
    check("wrap5.err",   32'(s_err), 0);

    // Reset mid-burst, away from any clock edge.
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    set_in(1'b1, 8'hD0, 1'b0, 1'b0);
    step();
    check("burst.count", 32'(s_count), 4);
    nRST = 1'b0;
    #1;
    check_all_zero("midrst");
    #2;
    nRST = 1'b1;
    step();
    check("post.wr_en", 32'(s_mem_wr_en), 1);
    check("post.waddr", 32'(s_waddr), 0);
    check("post.wdata", 32'(s_wdata), 32'hD0);
    check("post.count", 32'(s_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
